// File: rtl/cdb_slot_scheduler.sv
// cdb_slot_scheduler: reserves future Common Data Bus (CDB) broadcast slots
// when an op issues, so that results from the int ALU, load buffer,
// multiplier and divider never collide on the CDB.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   ready_int           int reservation station (RS) has a ready op
//   ready_mult          mult RS has a ready op
//   ready_div           div RS has a ready op
//   ready_ld_buf        load buffer has a ready entry
//   div_exec_ready      external divider reports idle
//   issue_int           grant to int RS (combinational)
//   issue_mult          grant to mult RS (combinational)
//   issue_div           grant to div RS (combinational)
//   issue_ls_buf        grant to load buffer (combinational)
//   cdb_sel[1:0]        CDB owner this cycle: 0 int, 1 mult, 2 div, 3 ld_buf (registered)
//   cdb_sel_valid       CDB carries a result this cycle (registered)
module cdb_slot_scheduler #(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready_int,
    input  logic       ready_mult,
    input  logic       ready_div,
    input  logic       ready_ld_buf,
    input  logic       div_exec_ready,
    output logic       issue_int,
    output logic       issue_mult,
    output logic       issue_div,
    output logic       issue_ls_buf,
    output logic [1:0] cdb_sel,
    output logic       cdb_sel_valid
);

    localparam int unsigned D     = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W = $clog2(DIV_LAT);

    localparam logic [1:0] OWN_INT  = 2'd0;
    localparam logic [1:0] OWN_MULT = 2'd1;
    localparam logic [1:0] OWN_DIV  = 2'd2;
    localparam logic [1:0] OWN_LD   = 2'd3;

    localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(DIV_LAT - 1);
    localparam logic             SAME_LAT   = (MULT_LAT == DIV_LAT);

    // Reservation table: entry k describes the CDB k cycles from now.
    logic [D:1]       res_valid;
    logic [1:0]       res_owner [1:D];
    logic [CNT_W-1:0] div_cnt;
    logic             rr;          // 0: int goes next on a tie, 1: ld_buf goes next
    logic             slot1_free;

    // Same-cycle grants; mult/div latencies are >= 2, so only R[1] gates int/ld.
    always_comb begin
        issue_div    = 1'b0;
        issue_mult   = 1'b0;
        issue_int    = 1'b0;
        issue_ls_buf = 1'b0;
        slot1_free   = 1'b0;
        if (!reset) begin
            issue_div    = ready_div & div_exec_ready & (div_cnt == '0) & ~res_valid[DIV_LAT];
            issue_mult   = ready_mult & ~res_valid[MULT_LAT] & ~(issue_div & SAME_LAT);
            slot1_free   = ~res_valid[1];
            issue_int    = slot1_free & ready_int & (~ready_ld_buf | ~rr);
            issue_ls_buf = slot1_free & ready_ld_buf & (~ready_int | rr);
        end
    end

    // Shift the table one slot per cycle, merging new mult/div reservations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid     <= '0;
            for (int unsigned k = 1; k <= D; k++) begin
                res_owner[k] <= OWN_INT;
            end
            cdb_sel       <= OWN_INT;
            cdb_sel_valid <= 1'b0;
            rr            <= 1'b0;
            div_cnt       <= '0;
        end else begin
            for (int unsigned k = 1; k < D; k++) begin
                if (issue_div && (k + 1 == DIV_LAT)) begin
                    res_valid[k] <= 1'b1;
                    res_owner[k] <= OWN_DIV;
                end else if (issue_mult && (k + 1 == MULT_LAT)) begin
                    res_valid[k] <= 1'b1;
                    res_owner[k] <= OWN_MULT;
                end else begin
                    res_valid[k] <= res_valid[k + 1];
                    res_owner[k] <= res_owner[k + 1];
                end
            end
            res_valid[D] <= 1'b0;
            res_owner[D] <= OWN_INT;

            // Next-cycle CDB owner: a held reservation or this cycle's slot-1 grant.
            cdb_sel_valid <= res_valid[1] | issue_int | issue_ls_buf;
            if (res_valid[1]) begin
                cdb_sel <= res_owner[1];
            end else if (issue_ls_buf) begin
                cdb_sel <= OWN_LD;
            end else begin
                cdb_sel <= OWN_INT;
            end

            if (issue_int) begin
                rr <= 1'b1;
            end else if (issue_ls_buf) begin
                rr <= 1'b0;
            end

            // Divider occupancy: blocks back-to-back divides regardless of div_exec_ready.
            if (issue_div) begin
                div_cnt <= DIV_RELOAD;
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Testbench for cdb_slot_scheduler: directed scenarios plus a randomized run
// checked against an absolute-cycle bus-booking model.
module tb_cdb_slot_scheduler;

    localparam int unsigned MULT_LAT = 4;
    localparam int unsigned DIV_LAT  = 7;
    localparam int NCYC = 600;

    logic       clk = 1'b0;
    logic       reset;
    logic       ready_int, ready_mult, ready_div, ready_ld_buf, div_exec_ready;
    logic       issue_int, issue_mult, issue_div, issue_ls_buf;
    logic [1:0] cdb_sel;
    logic       cdb_sel_valid;

    int errors = 0;
    int checks = 0;

    // Model: owner booked on the bus for each absolute cycle, -1 when free.
    int bus [0:NCYC+15];

    cdb_slot_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset),
        .ready_int(ready_int), .ready_mult(ready_mult), .ready_div(ready_div),
        .ready_ld_buf(ready_ld_buf), .div_exec_ready(div_exec_ready),
        .issue_int(issue_int), .issue_mult(issue_mult), .issue_div(issue_div),
        .issue_ls_buf(issue_ls_buf), .cdb_sel(cdb_sel), .cdb_sel_valid(cdb_sel_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic set_in(input logic i, input logic m, input logic d, input logic l, input logic x);
        ready_int = i; ready_mult = m; ready_div = d; ready_ld_buf = l; div_exec_ready = x;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge: "cycle 0" of a test.
    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1, 1, 1, 1, 1);
        @(posedge clk);
        #2;
        checks++; if ({issue_div, issue_mult, issue_int, issue_ls_buf} !== 4'b0000) begin
            errors++; $display("FAIL reset_issue: issue=%b expected 0000", {issue_div, issue_mult, issue_int, issue_ls_buf}); end
        checks++; if (cdb_sel_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: cdb_sel_valid=%b expected 0", cdb_sel_valid); end
        checks++; if (cdb_sel !== 2'd0) begin
            errors++; $display("FAIL reset_sel: cdb_sel=%0d expected 0", cdb_sel); end
    endtask

    task automatic test_int_single();
        do_reset();
        set_in(1, 0, 0, 0, 0); #1;
        checks++; if (issue_int !== 1'b1) begin
            errors++; $display("FAIL int_c0_issue: issue_int=%b expected 1", issue_int); end
        next_cycle();
        set_in(0, 0, 0, 0, 0); #1;
        checks++; if (cdb_sel_valid !== 1'b1 || cdb_sel !== 2'd0) begin
            errors++; $display("FAIL int_c1_cdb: valid=%b sel=%0d expected valid=1 sel=0", cdb_sel_valid, cdb_sel); end
        next_cycle();
        checks++; if (cdb_sel_valid !== 1'b0) begin
            errors++; $display("FAIL int_c2_valid: cdb_sel_valid=%b expected 0", cdb_sel_valid); end
    endtask

    task automatic test_mult_block();
        do_reset();
        set_in(0, 1, 0, 0, 0); #1;
        checks++; if (issue_mult !== 1'b1) begin
            errors++; $display("FAIL mult_c0_issue: issue_mult=%b expected 1", issue_mult); end
        next_cycle();
        set_in(0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        set_in(1, 0, 0, 0, 0); #1;
        checks++; if (issue_int !== 1'b0) begin
            errors++; $display("FAIL mult_c3_int_blocked: issue_int=%b expected 0", issue_int); end
        next_cycle();
        #1;
        checks++; if (issue_int !== 1'b1) begin
            errors++; $display("FAIL mult_c4_int: issue_int=%b expected 1", issue_int); end
        checks++; if (cdb_sel_valid !== 1'b1 || cdb_sel !== 2'd1) begin
            errors++; $display("FAIL mult_c4_cdb: valid=%b sel=%0d expected valid=1 sel=1", cdb_sel_valid, cdb_sel); end
        next_cycle();
        set_in(0, 0, 0, 0, 0); #1;
        checks++; if (cdb_sel_valid !== 1'b1 || cdb_sel !== 2'd0) begin
            errors++; $display("FAIL mult_c5_cdb: valid=%b sel=%0d expected valid=1 sel=0", cdb_sel_valid, cdb_sel); end
    endtask

    task automatic test_back_to_back_rr();
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            if (c < 4) set_in(1, 0, 0, 1, 0);
            else       set_in(0, 0, 0, 0, 0);
            #1;
            if (c < 4) begin
                checks++; if (issue_int !== ((c % 2) == 0) || issue_ls_buf !== ((c % 2) == 1)) begin
                    errors++; $display("FAIL rr_grant_c%0d: int=%b ld=%b expected int=%b ld=%b",
                                       c, issue_int, issue_ls_buf, (c % 2) == 0, (c % 2) == 1); end
            end
            if (c >= 1) begin
                checks++; if (cdb_sel_valid !== 1'b1 || cdb_sel !== (((c - 1) % 2 == 1) ? 2'd3 : 2'd0)) begin
                    errors++; $display("FAIL rr_cdb_c%0d: valid=%b sel=%0d expected valid=1 sel=%0d",
                                       c, cdb_sel_valid, cdb_sel, ((c - 1) % 2 == 1) ? 3 : 0); end
            end
            next_cycle();
        end
    endtask

    task automatic test_div_mult();
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            set_in(0, (c == 3 || c == 4), (c <= 7), 0, 1);
            #1;
            checks++; if (issue_div !== (c == 0 || c == 7)) begin
                errors++; $display("FAIL divmult_div_c%0d: issue_div=%b expected %b", c, issue_div, (c == 0 || c == 7)); end
            if (c == 3 || c == 4) begin
                checks++; if (issue_mult !== (c == 4)) begin
                    errors++; $display("FAIL divmult_mult_c%0d: issue_mult=%b expected %b", c, issue_mult, c == 4); end
            end
            if (c == 7 || c == 8) begin
                checks++; if (cdb_sel_valid !== 1'b1 || cdb_sel !== ((c == 7) ? 2'd2 : 2'd1)) begin
                    errors++; $display("FAIL divmult_cdb_c%0d: valid=%b sel=%0d expected valid=1 sel=%0d",
                                       c, cdb_sel_valid, cdb_sel, (c == 7) ? 2 : 1); end
            end
            next_cycle();
        end
    endtask

    task automatic test_div_exec_ready();
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            set_in(0, 0, 1, 0, (c >= 3));
            #1;
            checks++; if (issue_div !== (c == 3)) begin
                errors++; $display("FAIL divrdy_c%0d: issue_div=%b expected %b", c, issue_div, c == 3); end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(0, 1, 0, 0, 0); #1;
        checks++; if (issue_mult !== 1'b1) begin
            errors++; $display("FAIL rstmid_c0_issue: issue_mult=%b expected 1", issue_mult); end
        next_cycle();
        set_in(0, 0, 0, 0, 0);
        next_cycle();
        set_in(0, 1, 0, 0, 0);
        reset = 1'b1; #1;
        checks++; if (cdb_sel_valid !== 1'b0 || issue_mult !== 1'b0) begin
            errors++; $display("FAIL rstmid_c2: valid=%b issue_mult=%b expected 0 0", cdb_sel_valid, issue_mult); end
        next_cycle();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0);
        next_cycle();
        #1;
        checks++; if (cdb_sel_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_c4_valid: cdb_sel_valid=%b expected 0", cdb_sel_valid); end
    endtask

    task automatic test_random();
        int last_div;
        int rr_ld_next;
        logic ri, rm, rd, rl, rx, gd, gm, gi, gl;
        for (int i = 0; i <= NCYC + 15; i++) bus[i] = -1;
        last_div   = -100;
        rr_ld_next = 0;
        do_reset();
        for (int t = 0; t < NCYC; t++) begin
            ri = 1'($urandom_range(0, 1));
            rm = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            rx = ($urandom_range(0, 3) != 0);
            set_in(ri, rm, rd, rl, rx);
            #1;
            checks++; if (cdb_sel_valid !== (bus[t] >= 0)) begin
                errors++; $display("FAIL rand_valid_t%0d: cdb_sel_valid=%b expected %b", t, cdb_sel_valid, bus[t] >= 0); end
            if (bus[t] >= 0) begin
                checks++; if (int'(cdb_sel) != bus[t]) begin
                    errors++; $display("FAIL rand_sel_t%0d: cdb_sel=%0d expected %0d", t, cdb_sel, bus[t]); end
            end
            // Book the bus in absolute time; div is considered before mult.
            gd = rd && rx && (t - last_div >= int'(DIV_LAT)) && (bus[t + int'(DIV_LAT)] < 0);
            if (gd) begin bus[t + int'(DIV_LAT)] = 2; last_div = t; end
            gm = rm && (bus[t + int'(MULT_LAT)] < 0);
            if (gm) bus[t + int'(MULT_LAT)] = 1;
            gi = 1'b0; gl = 1'b0;
            if (bus[t + 1] < 0) begin
                if (ri && rl) begin
                    if (rr_ld_next == 1) gl = 1'b1; else gi = 1'b1;
                end else begin
                    gi = ri; gl = rl;
                end
            end
            if (gi) begin bus[t + 1] = 0; rr_ld_next = 1; end
            if (gl) begin bus[t + 1] = 3; rr_ld_next = 0; end
            checks++; if ({issue_div, issue_mult, issue_int, issue_ls_buf} !== {gd, gm, gi, gl}) begin
                errors++; $display("FAIL rand_issue_t%0d: div/mult/int/ld=%b expected %b",
                                   t, {issue_div, issue_mult, issue_int, issue_ls_buf}, {gd, gm, gi, gl}); end
            next_cycle();
        end
        set_in(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_int_single();
        test_mult_block();
        test_back_to_back_rr();
        test_div_mult();
        test_div_exec_ready();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
